pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 14 +
 rtl/pc_sequencer_if.sv | 31 +++
 rtl/pc_target_calc.sv | 39 +++
 rtl/pc_sequencer.sv | 105 ++++++++++
 tb/tb_pc_sequencer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and default addresses for the MIPS-style PC sequencer.
// Imported by the sequencer, its target calculator and the stimulus interface.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DELAY = 2'd1,
    ST_HALT  = 2'd2
  } pc_state_e;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;
  localparam logic [31:0] HALT_ADDR_DEF    = 32'h0000_0000;

endpackage

// File: rtl/pc_sequencer_if.sv
// Signal bundle for the sequencer's retire-side inputs and fetch-side outputs.
// An instruction retires when instr_valid=1 and stall=0; there is no ready back-pressure.
interface pc_sequencer_if;

  logic        stall;
  logic        instr_valid;
  logic        branch_taken;
  logic        jump;
  logic        jump_reg;
  logic [15:0] branch_offset;
  logic [25:0] jump_index;
  logic [31:0] reg_target;
  logic [31:0] pc;
  logic        active;
  logic        delay_slot;
  logic        dslot_err;
  logic        addr_err;

  modport master (
    output stall, instr_valid, branch_taken, jump, jump_reg,
           branch_offset, jump_index, reg_target,
    input  pc, active, delay_slot, dslot_err, addr_err
  );

  modport slave (
    input  stall, instr_valid, branch_taken, jump, jump_reg,
           branch_offset, jump_index, reg_target,
    output pc, active, delay_slot, dslot_err, addr_err
  );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational control-transfer target selection: pc+4, branch, J and JR targets.
// Priority among simultaneous requests is jump_reg > jump > branch_taken.
module pc_target_calc
  import pc_seq_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic        i_branch_taken,
  input  logic        i_jump,
  input  logic        i_jump_reg,
  input  logic [15:0] i_branch_offset,
  input  logic [25:0] i_jump_index,
  input  logic [31:0] i_reg_target,
  output logic [31:0] o_pc4,
  output logic [31:0] o_target,
  output logic        o_any_req
);

  logic [31:0] w_pc4;
  logic [31:0] w_branch_tgt;
  logic [31:0] w_jump_tgt;

  assign w_pc4        = i_pc + 32'd4;
  // Word offset: sign-extend then scale by 4 in one concatenation.
  assign w_branch_tgt = w_pc4 + {{14{i_branch_offset[15]}}, i_branch_offset, 2'b00};
  assign w_jump_tgt   = {w_pc4[31:28], i_jump_index, 2'b00};

  always_comb begin
    o_target = w_branch_tgt;
    if (i_jump_reg) begin
      o_target = i_reg_target;
    end else if (i_jump) begin
      o_target = w_jump_tgt;
    end
  end

  assign o_pc4     = w_pc4;
  assign o_any_req = i_branch_taken | i_jump | i_jump_reg;

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer with one architectural branch delay slot and a terminal HALT state.
// All state is registered; pc changes only on an advancing clock edge.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEF,
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        instr_valid,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [15:0] branch_offset,
  input  logic [25:0] jump_index,
  input  logic [31:0] reg_target,
  output logic [31:0] pc,
  output logic        active,
  output logic        delay_slot,
  output logic        dslot_err,
  output logic        addr_err,
  output pc_state_e   o_dbg_state
);

  pc_state_e   r_state,   w_state_nxt;
  logic [31:0] r_pc,      w_pc_nxt;
  logic [31:0] r_pending, w_pending_nxt;
  logic        r_dslot_err, w_dslot_err_nxt;
  logic        r_addr_err,  w_addr_err_nxt;

  logic [31:0] w_pc4;
  logic [31:0] w_target;
  logic        w_any_req;
  logic        w_advance;

  pc_target_calc u_target_calc (
    .i_pc            (r_pc),
    .i_branch_taken  (branch_taken),
    .i_jump          (jump),
    .i_jump_reg      (jump_reg),
    .i_branch_offset (branch_offset),
    .i_jump_index    (jump_index),
    .i_reg_target    (reg_target),
    .o_pc4           (w_pc4),
    .o_target        (w_target),
    .o_any_req       (w_any_req)
  );

  assign w_advance = instr_valid && !stall && (r_state != ST_HALT);

  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_pending_nxt   = r_pending;
    w_dslot_err_nxt = r_dslot_err;
    w_addr_err_nxt  = r_addr_err;
    if (w_advance) begin
      case (r_state)
        ST_RUN: begin
          w_pc_nxt = w_pc4;
          if (w_any_req) begin
            w_pending_nxt = w_target;
            w_state_nxt   = ST_DELAY;
            if (w_target[1:0] != 2'b00) w_addr_err_nxt = 1'b1;
          end
        end
        ST_DELAY: begin
          // Requests from the slot instruction itself are dropped and flagged.
          w_pc_nxt    = r_pending;
          w_state_nxt = (r_pending == HALT_ADDR) ? ST_HALT : ST_RUN;
          if (w_any_req) w_dslot_err_nxt = 1'b1;
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_pc        <= RESET_VECTOR;
      r_pending   <= 32'd0;
      r_dslot_err <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_pending   <= w_pending_nxt;
      r_dslot_err <= w_dslot_err_nxt;
      r_addr_err  <= w_addr_err_nxt;
    end
  end

  assign pc          = r_pc;
  assign active      = (r_state != ST_HALT);
  assign delay_slot  = (r_state == ST_DELAY);
  assign dslot_err   = r_dslot_err;
  assign addr_err    = r_addr_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations, then random
// retire streams checked every cycle against an architectural model of the PC.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam logic [31:0] RV   = 32'hBFC0_0000;
  localparam logic [31:0] HALT = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_sequencer_if bus ();
  pc_state_e dbg_state;

  pc_sequencer #(
    .RESET_VECTOR (RV),
    .HALT_ADDR    (HALT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (bus.stall),
    .instr_valid   (bus.instr_valid),
    .branch_taken  (bus.branch_taken),
    .jump          (bus.jump),
    .jump_reg      (bus.jump_reg),
    .branch_offset (bus.branch_offset),
    .jump_index    (bus.jump_index),
    .reg_target    (bus.reg_target),
    .pc            (bus.pc),
    .active        (bus.active),
    .delay_slot    (bus.delay_slot),
    .dslot_err     (bus.dslot_err),
    .addr_err      (bus.addr_err),
    .o_dbg_state   (dbg_state)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- architectural model ----------------
  // The model thinks in terms of "next fetch address", "owed jump" and "halted",
  // with targets computed by ordinary integer arithmetic.
  logic [31:0] m_pc;
  logic [31:0] m_owed;
  bit          m_in_slot;
  bit          m_halted;
  bit          m_dserr;
  bit          m_aerr;
  bit          m_ready = 0;

  function automatic logic [31:0] model_target(input logic [31:0] cur);
    longint t;
    if (bus.jump_reg) return bus.reg_target;
    if (bus.jump) return ((cur + 32'd4) & 32'hF000_0000) | (32'(bus.jump_index) * 32'd4);
    t = longint'(cur) + 4 + 4 * longint'($signed(bus.branch_offset));
    return t[31:0];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pc = RV; m_owed = 0; m_in_slot = 0; m_halted = 0;
      m_dserr = 0; m_aerr = 0; m_ready = 1;
    end else if (bus.instr_valid && !bus.stall && !m_halted) begin
      if (m_in_slot) begin
        if (bus.jump_reg || bus.jump || bus.branch_taken) m_dserr = 1;
        m_pc      = m_owed;
        m_in_slot = 0;
        m_halted  = (m_owed == HALT);
      end else begin
        if (bus.jump_reg || bus.jump || bus.branch_taken) begin
          m_owed    = model_target(m_pc);
          m_in_slot = 1;
          if (m_owed % 4 != 0) m_aerr = 1;
        end
        m_pc = m_pc + 32'd4;
      end
    end
  end

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    if (m_ready) begin
      chk("pc",         bus.pc,         m_pc);
      chk("active",     32'(bus.active),     32'(!m_halted));
      chk("delay_slot", 32'(bus.delay_slot), 32'(m_in_slot));
      chk("dslot_err",  32'(bus.dslot_err),  32'(m_dserr));
      chk("addr_err",   32'(bus.addr_err),   32'(m_aerr));
      chk("dbg_halt",   32'(dbg_state == ST_HALT), 32'(m_halted));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input bit v, input bit s, input bit bt, input bit j, input bit jr,
                     input logic [15:0] off, input logic [25:0] idx, input logic [31:0] rt);
    bus.instr_valid   = v;
    bus.stall         = s;
    bus.branch_taken  = bt;
    bus.jump          = j;
    bus.jump_reg      = jr;
    bus.branch_offset = off;
    bus.jump_index    = idx;
    bus.reg_target    = rt;
    @(negedge clk);
  endtask

  task automatic adv();
    cyc(1, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.instr_valid = 0; bus.stall = 0; bus.branch_taken = 0; bus.jump = 0;
    bus.jump_reg = 0; bus.branch_offset = 0; bus.jump_index = 0; bus.reg_target = 0;
    @(negedge clk);
    do_reset();
    cyc(0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
    chk("rst_pc",     bus.pc, 32'hBFC0_0000);
    chk("rst_active", 32'(bus.active), 32'd1);
    chk("rst_dslot",  32'(bus.delay_slot), 32'd0);
    chk("rst_errs",   {30'd0, bus.dslot_err, bus.addr_err}, 32'd0);

    // three plain advances
    adv(); adv(); adv();
    chk("plain3_pc", bus.pc, 32'hBFC0_000C);
    chk("plain3_model", m_pc, 32'hBFC0_000C);

    // alternating stall: six cycles, three advances
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(1, (i % 2) == 0, 0, 0, 0, 16'h0, 26'h0, 32'h0);
      if (i == 0) chk("stall_hold_pc", bus.pc, 32'hBFC0_0000);
    end
    chk("stall6_pc", bus.pc, 32'hBFC0_000C);

    // backward branch by one word
    do_reset();
    cyc(1, 0, 1, 0, 0, 16'hFFFF, 26'h0, 32'h0);
    chk("br_slot_pc", bus.pc, 32'hBFC0_0004);
    chk("br_slot_flag", 32'(bus.delay_slot), 32'd1);
    adv();
    chk("br_tgt_pc", bus.pc, 32'hBFC0_0000);
    chk("br_tgt_model", m_pc, 32'hBFC0_0000);

    // J from BFC00010
    do_reset();
    adv(); adv(); adv(); adv();
    cyc(1, 0, 0, 1, 0, 16'h0, 26'h0000100, 32'h0);
    chk("j_slot_pc", bus.pc, 32'hBFC0_0014);
    adv();
    chk("j_tgt_pc", bus.pc, 32'hB000_0400);
    chk("j_tgt_model", m_pc, 32'hB000_0400);

    // JR to halt address
    do_reset();
    cyc(1, 0, 0, 0, 1, 16'h0, 26'h0, 32'h0);
    chk("jr0_slot_pc", bus.pc, 32'hBFC0_0004);
    adv();
    chk("halt_pc", bus.pc, 32'h0);
    chk("halt_active", 32'(bus.active), 32'd0);
    adv(); adv();
    chk("halt_hold_pc", bus.pc, 32'h0);
    do_reset();
    chk("halt_rst_pc", bus.pc, 32'hBFC0_0000);
    chk("halt_rst_active", 32'(bus.active), 32'd1);

    // misaligned JR, stalled delay slot carrying a branch
    do_reset();
    cyc(1, 0, 0, 0, 1, 16'h0, 26'h0, 32'h0000_0402);
    chk("mis_aerr_latch", 32'(bus.addr_err), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 1, 0, 0, 16'h0010, 26'h0, 32'h0);
      chk("mis_stall_pc", bus.pc, 32'hBFC0_0004);
    end
    chk("mis_dserr_pre", 32'(bus.dslot_err), 32'd0);
    cyc(1, 0, 1, 0, 0, 16'h0010, 26'h0, 32'h0);
    chk("mis_pc", bus.pc, 32'h0000_0402);
    chk("mis_dserr", 32'(bus.dslot_err), 32'd1);
    chk("mis_aerr", 32'(bus.addr_err), 32'd1);

    // random retire stream
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] rt;
      case ($urandom_range(0, 3))
        0:       rt = HALT;
        1:       rt = $urandom & 32'hFFFF_FFFC;
        2:       rt = $urandom;
        default: rt = {$urandom_range(0, 15), 28'd0} | ($urandom & 32'h0000_FFFC);
      endcase
      rst = ($urandom_range(0, 49) == 0);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0,
          16'($urandom), 26'($urandom), rt);
    end
    rst = 1'b0;
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
